seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit 7-segment display bus: monitors the anode strobes and segment lines driven by the display scanner.
- Reconstructs the four hex digits being shown.
- Sits beside the display driver as a loop-back checker, or on a sniffed external display.
- Publishes a 16-bit value once per complete scan frame, and flags illegal bus states and a stalled scan.

Parameters:
- SETTLE, 2, consecutive stable cycles required on {an,seg} before a digit is sampled (1..15).
- TIMEOUT, 1024, cycles without any digit sample before stale asserts (≥ 4·(SETTLE+2)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- an  in  4  anode strobes, active-low; an[0] = digit 0 (least significant).
- seg  in  7  segment lines, active-low; seg[0]=a … seg[6]=g.
- value  out  16  last complete frame; digit k in value[4k+3:4k].
- frame_valid  out  1  one-cycle pulse when value updates.
- digit_ok  out  4  per-digit flag: 1 = last capture of that digit decoded to a legal hex glyph.
- err  out  1  one-cycle pulse on an illegal anode pattern or an undecodable glyph.
- stale  out  1  level; high when no sample has occurred for TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0): value=0, frame_valid=0, digit_ok=0, err=0, stale=0, capture mask=0, all counters=0, input register r_in={an,seg}=11'h7FF.
- Input stage: r_in <= {an,seg} every edge.
- Stability counter cnt:
  - cleared when {an,seg} != r_in;
  - otherwise increments, saturating at SETTLE+1.
- Sample strobe: asserted in the cycle where cnt==SETTLE. Exactly one strobe per stable interval.
  - Net effect: an input held constant from before edge 0 is captured at edge SETTLE+1.
- Anode decode at strobe:
  - 1110→digit 0, 1101→1, 1011→2, 0111→3.
  - 1111 (blanking): no capture, no error.
  - Any other pattern: err pulse, no capture, mask unchanged.
- Glyph decode at strobe (seg, hex, 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Legal glyph: shadow[k] <= nibble, digit_ok[k] <= 1, mask[k] <= 1.
- Illegal glyph: shadow[k] unchanged, digit_ok[k] <= 0, mask[k] <= 1, err pulse.
- Frame completion: on the capture edge where mask (including the new bit) becomes 4'b1111:
  - value <= shadow with the new nibble merged;
  - frame_valid = 1 for that following cycle;
  - mask <= 0;
  - stale <= 0.
- Scan order is irrelevant. Repeat captures of a digit before completion overwrite shadow[k] without completing the frame.
- Stale timer:
  - counts cycles since the last sample strobe and is cleared by any strobe, including blank or illegal ones;
  - at TIMEOUT it saturates, stale <= 1, mask <= 0;
  - value and digit_ok are held.
- Simultaneous events: a strobe on the same edge the timer would reach TIMEOUT wins (timer clears, stale unchanged).
- Reset mid-frame: mask discarded, all outputs return to reset values immediately.
- err and frame_valid may assert in the same cycle only when an illegal glyph completes the mask.

Test Plan (SETTLE=2, TIMEOUT=64):
- Scan 1234 (an=1110/seg=19, 1101/30, 1011/24, 0111/79), 8 cycles per digit → frame_valid pulses once per scan, value=16'h1234, digit_ok=4'hF, err never asserts.
- an/seg changes every cycle (held 2 cycles < SETTLE+1) → no capture, no frame_valid; stale asserts 64 cycles after the last strobe.
- an=1100 held 8 cycles → single err pulse, mask unchanged; a later full scan of 0000 → value=16'h0000.
- Digit 2 glyph seg=7'h7F within scan ABCD → err pulse, digit_ok=4'b1011, value[11:8] keeps previous nibble; frame_valid still pulses.
- Order 3,1,0,3,2 with values F,E,D,C,B → single frame_valid after digit 2, value=16'hCBED.
- rst_n low for 1 cycle after 3 digits captured → outputs zero immediately; the next single digit does not produce frame_valid.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the sniffed 7-segment display bus together with the decoded results.
//   an[3:0]      anode strobes, active-low, an[0] = least significant digit
//   seg[6:0]     segment lines, active-low, seg[0] = a ... seg[6] = g
//   value[15:0]  last complete frame, digit k in value[4k+3:4k]
//   frame_valid  one-cycle pulse when value updates
//   digit_ok[3:0] per-digit "last capture was a legal hex glyph"
//   err          one-cycle pulse on an illegal anode pattern or glyph
//   stale        level, no digit sample seen for TIMEOUT cycles
// master: whoever drives the display bus and consumes the results.
// slave : the decoder itself.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_ok;
    logic        err;
    logic        stale;

    modport master (
        output an, seg,
        input  value, frame_valid, digit_ok, err, stale
    );

    modport slave (
        input  an, seg,
        output value, frame_valid, digit_ok, err, stale
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Watches a multiplexed 4-digit 7-segment display bus and rebuilds the four hex
// digits being shown. A digit is sampled once {an,seg} has been stable for
// SETTLE cycles; when all four digits have been captured the 16-bit value is
// published with a one-cycle frame_valid pulse. Illegal anode patterns and
// undecodable glyphs pulse err; a scan that stops producing samples for
// TIMEOUT cycles raises stale and discards the partial frame.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_decoder_if.slave (an/seg in, decoded results out)
// Parameters:
//   SETTLE  stable cycles required before a sample (1..15)
//   TIMEOUT cycles without a sample before stale asserts
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int CW = $clog2(SETTLE + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_STB = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE + 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

    logic [10:0]      r_in;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tmr;
    logic [3:0]       mask;
    logic [3:0][3:0]  shadow;
    logic [15:0]      value_q;
    logic             frame_valid_q;
    logic [3:0]       digit_ok_q;
    logic             err_q;
    logic             stale_q;

    logic             strobe;
    logic             dig_hit;
    logic             an_bad;
    logic [1:0]       dig_idx;
    logic [3:0]       dig_sel;
    logic             glyph_ok;
    logic [3:0]       glyph_nib;
    logic [3:0]       mask_nxt;
    logic [3:0][3:0]  shadow_nxt;

    // cnt saturates one above SETTLE, so cnt==SETTLE holds for exactly one
    // cycle per stable interval.
    assign strobe = (cnt == CNT_STB);

    always_comb begin
        dig_hit = 1'b1;
        an_bad  = 1'b0;
        dig_idx = 2'd0;
        case (r_in[10:7])
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            4'b1111: dig_hit = 1'b0;
            default: begin
                dig_hit = 1'b0;
                an_bad  = 1'b1;
            end
        endcase
    end

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (r_in[6:0])
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h78: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h03: glyph_nib = 4'hB;
            7'h46: glyph_nib = 4'hC;
            7'h21: glyph_nib = 4'hD;
            7'h06: glyph_nib = 4'hE;
            7'h0E: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Shadow with the incoming nibble merged; an illegal glyph leaves the
    // previous nibble in place so a completed frame still carries it.
    always_comb begin
        dig_sel    = 4'b0001 << dig_idx;
        mask_nxt   = mask | dig_sel;
        shadow_nxt = shadow;
        if (glyph_ok)
            shadow_nxt[dig_idx] = glyph_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in          <= 11'h7FF;
            cnt           <= '0;
            tmr           <= '0;
            mask          <= 4'b0000;
            shadow        <= '0;
            value_q       <= 16'h0000;
            frame_valid_q <= 1'b0;
            digit_ok_q    <= 4'b0000;
            err_q         <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            r_in          <= {bus.an, bus.seg};
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;

            if ({bus.an, bus.seg} != r_in)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (strobe) begin
                // Any sample, even blank or illegal, proves the scan is alive.
                tmr <= '0;
                if (an_bad) begin
                    err_q <= 1'b1;
                end else if (dig_hit) begin
                    shadow              <= shadow_nxt;
                    digit_ok_q[dig_idx] <= glyph_ok;
                    if (!glyph_ok)
                        err_q <= 1'b1;
                    if (mask_nxt == 4'b1111) begin
                        value_q       <= shadow_nxt;
                        frame_valid_q <= 1'b1;
                        mask          <= 4'b0000;
                        stale_q       <= 1'b0;
                    end else begin
                        mask <= mask_nxt;
                    end
                end
            end else if (tmr != TMR_MAX) begin
                tmr <= tmr + 1'b1;
                if (tmr == TMR_MAX - 1'b1) begin
                    stale_q <= 1'b1;
                    mask    <= 4'b0000;
                end
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.digit_ok    = digit_ok_q;
    assign bus.err         = err_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed stimulus on the display bus; a behavioural model tracks how long the
// bus has been stable, which digits of the current frame have been seen and
// the time since the last sample, and the DUT outputs are compared against it
// on every falling edge. Literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [3:0] ANODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic clk;
    logic rst_n;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [10:0] prev_in;
    int          run;
    int          since;
    logic [3:0]  m_shadow [4];
    bit          m_cap [4];
    logic [15:0] m_value;
    logic [3:0]  m_ok;
    bit          m_fv, m_err, m_stale;

    initial begin
        logic [10:0] cur;
        logic [3:0]  a;
        logic [6:0]  s;
        int          k;
        int          nib;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_in = 11'h7FF;
                run     = 1;
                since   = 0;
                m_value = 16'h0;
                m_ok    = 4'h0;
                m_fv    = 0;
                m_err   = 0;
                m_stale = 0;
                for (int i = 0; i < 4; i++) begin
                    m_shadow[i] = 4'h0;
                    m_cap[i]    = 0;
                end
            end else begin
                cur   = {bus.an, bus.seg};
                m_fv  = 0;
                m_err = 0;
                // run = number of consecutive edges that have seen this value
                if (cur == prev_in) begin
                    if (run <= SETTLE + 2) run++;
                end else begin
                    run = 1;
                end
                prev_in = cur;
                if (run == SETTLE + 2) begin
                    since = 0;
                    a = cur[10:7];
                    s = cur[6:0];
                    k = -1;
                    for (int i = 0; i < 4; i++) if (a == ANODE[i]) k = i;
                    if (a != 4'hF) begin
                        if (k < 0) begin
                            m_err = 1;
                        end else begin
                            nib = -1;
                            for (int g = 0; g < 16; g++) if (GLYPH[g] == s) nib = g;
                            m_cap[k] = 1;
                            if (nib >= 0) begin
                                m_shadow[k] = nib[3:0];
                                m_ok[k]     = 1'b1;
                            end else begin
                                m_ok[k] = 1'b0;
                                m_err   = 1;
                            end
                            if (m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3]) begin
                                m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
                                m_fv    = 1;
                                m_stale = 0;
                                for (int i = 0; i < 4; i++) m_cap[i] = 0;
                            end
                        end
                    end
                end else if (since < TIMEOUT) begin
                    since++;
                    if (since == TIMEOUT) begin
                        m_stale = 1;
                        for (int i = 0; i < 4; i++) m_cap[i] = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("value",       bus.value,              m_value);
            chk("frame_valid", 16'(bus.frame_valid),   16'(m_fv));
            chk("digit_ok",    16'(bus.digit_ok),      16'(m_ok));
            chk("err",         16'(bus.err),           16'(m_err));
            chk("stale",       16'(bus.stale),         16'(m_stale));
            if (bus.frame_valid === 1'b1) fv_cnt++;
            if (bus.err === 1'b1) err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] v);
        for (int k = 0; k < 4; k++)
            drive(ANODE[k], GLYPH[v[4*k +: 4]], 8);
    endtask

    initial begin
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value",    bus.value,            16'h0000);
        chk("rst_fv",       16'(bus.frame_valid), 16'h0);
        chk("rst_digit_ok", 16'(bus.digit_ok),    16'h0);
        chk("rst_err",      16'(bus.err),         16'h0);
        chk("rst_stale",    16'(bus.stale),       16'h0);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 4);

        // two clean scans of 1234
        scan(16'h1234);
        scan(16'h1234);
        chk("scan1234_value", bus.value,         16'h1234);
        chk("scan1234_ok",    16'(bus.digit_ok), 16'h000F);
        chk("scan1234_fvcnt", 16'(fv_cnt),       16'd2);
        chk("scan1234_errcnt",16'(err_cnt),      16'd0);

        // bus never stable long enough: no sample, eventually stale
        for (int i = 0; i < 40; i++) begin
            drive(4'b1110, 7'h19, 2);
            drive(4'b1101, 7'h30, 2);
        end
        chk("toggle_fvcnt", 16'(fv_cnt),     16'd2);
        chk("toggle_stale", 16'(bus.stale),  16'h1);
        chk("toggle_value", bus.value,       16'h1234);

        // two anodes at once: one err pulse, no capture
        drive(4'b1100, 7'h19, 8);
        chk("badan_errcnt", 16'(err_cnt),    16'd1);
        chk("badan_stale",  16'(bus.stale),  16'h1);
        scan(16'h0000);
        chk("scan0000_value", bus.value,      16'h0000);
        chk("scan0000_stale", 16'(bus.stale), 16'h0);
        chk("scan0000_fvcnt", 16'(fv_cnt),    16'd3);

        // illegal glyph on digit 2 keeps the previous nibble (6)
        scan(16'h5678);
        drive(4'b1110, GLYPH[13], 8);
        drive(4'b1101, GLYPH[12], 8);
        drive(4'b1011, 7'h7F, 8);
        drive(4'b0111, GLYPH[10], 8);
        chk("badglyph_value",  bus.value,         16'hA6CD);
        chk("badglyph_ok",     16'(bus.digit_ok), 16'b1011);
        chk("badglyph_errcnt", 16'(err_cnt),      16'd2);
        chk("badglyph_fvcnt",  16'(fv_cnt),       16'd5);

        // out-of-order scan with a repeated digit
        drive(4'b0111, GLYPH[15], 8);
        drive(4'b1101, GLYPH[14], 8);
        drive(4'b1110, GLYPH[13], 8);
        drive(4'b0111, GLYPH[12], 8);
        chk("order_nofv", 16'(fv_cnt), 16'd5);
        drive(4'b1011, GLYPH[11], 8);
        chk("order_value", bus.value,      16'hCBED);
        chk("order_fvcnt", 16'(fv_cnt),    16'd6);
        chk("order_ok",    16'(bus.digit_ok), 16'h000F);

        // reset part way through a frame
        drive(4'b1110, GLYPH[1], 8);
        drive(4'b1101, GLYPH[2], 8);
        drive(4'b1011, GLYPH[3], 8);
        drive(4'hF, 7'h7F, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_value", bus.value,         16'h0000);
        chk("midrst_ok",    16'(bus.digit_ok), 16'h0);
        chk("midrst_stale", 16'(bus.stale),    16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0111, GLYPH[9], 8);
        chk("postrst_fvcnt", 16'(fv_cnt),       16'd6);
        chk("postrst_value", bus.value,         16'h0000);
        chk("postrst_ok",    16'(bus.digit_ok), 16'b1000);
        drive(4'hF, 7'h7F, 4);
        chk("final_errcnt",  16'(err_cnt),      16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
